// File: rtl/hand_scorer.sv
// hand_scorer: per-hand modular card-score accumulator with a valid/ready card
// port, natural/closed detection, a one-cycle update pulse and a sticky
// illegal-card flag.
module hand_scorer #(
    parameter int NUM_HANDS = 2,
    parameter int MAX_CARDS = 3,
    parameter int MODULUS   = 10,
    parameter int HW        = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    parameter int CW        = $clog2(MAX_CARDS + 1)
) (
    input  logic                    slow_clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    card_valid,
    output logic                    card_ready,
    input  logic [HW-1:0]           card_hand,
    input  logic [3:0]              card,
    output logic [NUM_HANDS*4-1:0]  score,
    output logic [NUM_HANDS*CW-1:0] count,
    output logic [NUM_HANDS-1:0]    natural,
    output logic [NUM_HANDS-1:0]    full,
    output logic                    upd_valid,
    output logic [HW-1:0]           upd_hand,
    output logic                    err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        OPEN  = 2'd1,
        NAT   = 2'd2,
        FULL  = 2'd3
    } hand_state_e;

    hand_state_e   state_q [NUM_HANDS];
    hand_state_e   state_d [NUM_HANDS];
    logic [3:0]    score_q [NUM_HANDS];
    logic [3:0]    score_d [NUM_HANDS];
    logic [CW-1:0] count_q [NUM_HANDS];
    logic [CW-1:0] count_d [NUM_HANDS];
    logic          err_q, err_d;
    logic          upd_valid_q, upd_valid_d;
    logic [HW-1:0] upd_hand_q, upd_hand_d;

    logic          hand_open;
    logic          card_legal;
    logic [3:0]    card_value;
    logic [4:0]    sum;
    logic [3:0]    new_score;
    logic [CW-1:0] new_count;

    // Ace counts 1, pips their face value, tens and court cards 0.
    assign card_legal = (card != 4'd0) && (card <= 4'd13);
    assign card_value = (card <= 4'd9) ? card : 4'd0;

    // Ready when the addressed hand can still take a card; an index beyond
    // NUM_HANDS matches no hand and therefore is never ready.
    always_comb begin
        hand_open = 1'b0;
        for (int unsigned h = 0; h < NUM_HANDS; h++) begin
            if (card_hand == HW'(h)) begin
                hand_open = (state_q[h] == EMPTY) || (state_q[h] == OPEN);
            end
        end
        card_ready = !reset && !clear && hand_open;
    end

    // Next-state: clear wins over an offer; illegal cards only raise err.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        count_d     = count_q;
        err_d       = err_q;
        upd_valid_d = 1'b0;
        upd_hand_d  = upd_hand_q;
        sum         = '0;
        new_score   = '0;
        new_count   = '0;
        if (clear) begin
            for (int unsigned h = 0; h < NUM_HANDS; h++) begin
                state_d[h] = EMPTY;
                score_d[h] = '0;
                count_d[h] = '0;
            end
        end else if (card_valid && card_ready) begin
            if (!card_legal) begin
                err_d = 1'b1;
            end else begin
                for (int unsigned h = 0; h < NUM_HANDS; h++) begin
                    if (card_hand == HW'(h)) begin
                        sum       = {1'b0, score_q[h]} + {1'b0, card_value};
                        new_score = (sum >= 5'(MODULUS)) ? 4'(sum - 5'(MODULUS)) : sum[3:0];
                        new_count = count_q[h] + CW'(1);
                        score_d[h] = new_score;
                        count_d[h] = new_count;
                        if ((new_count == CW'(2)) && (new_score >= 4'd8)) begin
                            state_d[h] = NAT;
                        end else if (new_count == CW'(MAX_CARDS)) begin
                            state_d[h] = FULL;
                        end else begin
                            state_d[h] = OPEN;
                        end
                    end
                end
                upd_valid_d = 1'b1;
                upd_hand_d  = card_hand;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            for (int unsigned h = 0; h < NUM_HANDS; h++) begin
                state_q[h] <= EMPTY;
                score_q[h] <= '0;
                count_q[h] <= '0;
            end
            err_q       <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_hand_q  <= '0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            count_q     <= count_d;
            err_q       <= err_d;
            upd_valid_q <= upd_valid_d;
            upd_hand_q  <= upd_hand_d;
        end
    end

    // Pack per-hand registers onto the flat output buses.
    always_comb begin
        score   = '0;
        count   = '0;
        natural = '0;
        full    = '0;
        for (int unsigned h = 0; h < NUM_HANDS; h++) begin
            score[h*4 +: 4]   = score_q[h];
            count[h*CW +: CW] = count_q[h];
            natural[h]        = (state_q[h] == NAT);
            full[h]           = (state_q[h] == NAT) || (state_q[h] == FULL);
        end
    end

    assign upd_valid = upd_valid_q;
    assign upd_hand  = upd_hand_q;
    assign err       = err_q;

endmodule

// File: tb/tb_hand_scorer.sv
// tb_hand_scorer: directed vector table plus a reset-hold sequence for
// hand_scorer with default parameters (2 hands, 3 cards, modulus 10).
module tb_hand_scorer;

    logic       slow_clock = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       card_valid = 1'b0;
    logic       card_ready;
    logic [0:0] card_hand = 1'b0;
    logic [3:0] card = 4'd0;
    logic [7:0] score;
    logic [3:0] count;
    logic [1:0] natural;
    logic [1:0] full;
    logic       upd_valid;
    logic [0:0] upd_hand;
    logic       err;

    int checks = 0;
    int errors = 0;
    int vidx   = 0;

    hand_scorer #(
        .NUM_HANDS (2),
        .MAX_CARDS (3),
        .MODULUS   (10)
    ) dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .clear      (clear),
        .card_valid (card_valid),
        .card_ready (card_ready),
        .card_hand  (card_hand),
        .card       (card),
        .score      (score),
        .count      (count),
        .natural    (natural),
        .full       (full),
        .upd_valid  (upd_valid),
        .upd_hand   (upd_hand),
        .err        (err)
    );

    always #5 slow_clock = ~slow_clock;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       vld;
        logic       hand;
        logic [3:0] card;
        logic       rdy;
        logic       upd;
        logic       uh;
        logic [7:0] sc;
        logic [3:0] cn;
        logic [1:0] nat;
        logic [1:0] ful;
        logic       er;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic clr, input logic vld,
                                input logic hand, input logic [3:0] cd,
                                input logic rdy, input logic upd, input logic uh,
                                input logic [7:0] sc, input logic [3:0] cn,
                                input logic [1:0] nat, input logic [1:0] ful,
                                input logic er);
        vec_t v;
        v.rst = rst; v.clr = clr; v.vld = vld; v.hand = hand; v.card = cd;
        v.rdy = rdy; v.upd = upd; v.uh = uh; v.sc = sc; v.cn = cn;
        v.nat = nat; v.ful = ful; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %0h expected %0h", name, vidx, act, exp);
        end
    endtask

    vec_t vecs [28];

    initial begin
        //              rst clr vld h card  rdy upd uh score  count nat    full  err
        vecs[0]  = mk(1, 0, 1, 0, 4'd5,  0, 0, 0, 8'h00, 4'h0, 2'b00, 2'b00, 0);
        // hand 0: 1, 9, 6 -> 1, 0, 6, closed at three cards
        vecs[1]  = mk(0, 0, 1, 0, 4'd1,  1, 1, 0, 8'h01, 4'h1, 2'b00, 2'b00, 0);
        vecs[2]  = mk(0, 0, 1, 0, 4'd9,  1, 1, 0, 8'h00, 4'h2, 2'b00, 2'b00, 0);
        vecs[3]  = mk(0, 0, 1, 0, 4'd6,  1, 1, 0, 8'h06, 4'h3, 2'b00, 2'b01, 0);
        vecs[4]  = mk(0, 0, 1, 0, 4'd2,  0, 0, 0, 8'h06, 4'h3, 2'b00, 2'b01, 0);
        // hand 1: 3, 5 -> natural 8, third offer refused
        vecs[5]  = mk(0, 0, 1, 1, 4'd3,  1, 1, 1, 8'h36, 4'h7, 2'b00, 2'b01, 0);
        vecs[6]  = mk(0, 0, 1, 1, 4'd5,  1, 1, 1, 8'h86, 4'hB, 2'b10, 2'b11, 0);
        vecs[7]  = mk(0, 0, 1, 1, 4'd4,  0, 0, 1, 8'h86, 4'hB, 2'b10, 2'b11, 0);
        // clear together with an offer: offer dropped, all hands empty
        vecs[8]  = mk(0, 1, 1, 0, 4'd3,  0, 0, 1, 8'h00, 4'h0, 2'b00, 2'b00, 0);
        // hand 0: 3, 10, 2 -> 3, 3, 5
        vecs[9]  = mk(0, 0, 1, 0, 4'd3,  1, 1, 0, 8'h03, 4'h1, 2'b00, 2'b00, 0);
        vecs[10] = mk(0, 0, 1, 0, 4'd10, 1, 1, 0, 8'h03, 4'h2, 2'b00, 2'b00, 0);
        vecs[11] = mk(0, 0, 1, 0, 4'd2,  1, 1, 0, 8'h05, 4'h3, 2'b00, 2'b01, 0);
        vecs[12] = mk(0, 1, 0, 0, 4'd0,  0, 0, 0, 8'h00, 4'h0, 2'b00, 2'b00, 0);
        // 9 then 8 -> 17 mod 10 = 7, not natural
        vecs[13] = mk(0, 0, 1, 0, 4'd9,  1, 1, 0, 8'h09, 4'h1, 2'b00, 2'b00, 0);
        vecs[14] = mk(0, 0, 1, 0, 4'd8,  1, 1, 0, 8'h07, 4'h2, 2'b00, 2'b00, 0);
        // illegal codes 14 and 0: handshake, err, no update
        vecs[15] = mk(0, 0, 1, 0, 4'd14, 1, 0, 0, 8'h07, 4'h2, 2'b00, 2'b00, 1);
        vecs[16] = mk(0, 0, 1, 1, 4'd0,  1, 0, 0, 8'h07, 4'h2, 2'b00, 2'b00, 1);
        vecs[17] = mk(0, 1, 0, 0, 4'd0,  0, 0, 0, 8'h00, 4'h0, 2'b00, 2'b00, 1);
        vecs[18] = mk(1, 0, 0, 0, 4'd0,  0, 0, 0, 8'h00, 4'h0, 2'b00, 2'b00, 0);
        // reset mid-hand, with an offer in the reset cycle
        vecs[19] = mk(0, 0, 1, 0, 4'd4,  1, 1, 0, 8'h04, 4'h1, 2'b00, 2'b00, 0);
        vecs[20] = mk(0, 0, 1, 0, 4'd2,  1, 1, 0, 8'h06, 4'h2, 2'b00, 2'b00, 0);
        vecs[21] = mk(1, 0, 1, 0, 4'd1,  0, 0, 0, 8'h00, 4'h0, 2'b00, 2'b00, 0);
        // alternating hands: h0 7,6,1 -> 7,3,4 ; h1 9,K -> 9,9 natural
        vecs[22] = mk(0, 0, 1, 0, 4'd7,  1, 1, 0, 8'h07, 4'h1, 2'b00, 2'b00, 0);
        vecs[23] = mk(0, 0, 1, 1, 4'd9,  1, 1, 1, 8'h97, 4'h5, 2'b00, 2'b00, 0);
        vecs[24] = mk(0, 0, 1, 0, 4'd6,  1, 1, 0, 8'h93, 4'h6, 2'b00, 2'b00, 0);
        vecs[25] = mk(0, 0, 1, 1, 4'd13, 1, 1, 1, 8'h93, 4'hA, 2'b10, 2'b10, 0);
        vecs[26] = mk(0, 0, 1, 0, 4'd1,  1, 1, 0, 8'h94, 4'hB, 2'b10, 2'b11, 0);
        vecs[27] = mk(0, 0, 0, 0, 4'd0,  0, 0, 0, 8'h94, 4'hB, 2'b10, 2'b11, 0);

        for (int i = 0; i < 28; i++) begin
            @(negedge slow_clock);
            vidx       = i;
            reset      = vecs[i].rst;
            clear      = vecs[i].clr;
            card_valid = vecs[i].vld;
            card_hand  = vecs[i].hand;
            card       = vecs[i].card;
            #1;
            chk("card_ready", 32'(card_ready), 32'(vecs[i].rdy));
            @(posedge slow_clock);
            #1;
            chk("upd_valid", 32'(upd_valid), 32'(vecs[i].upd));
            chk("upd_hand",  32'(upd_hand),  32'(vecs[i].uh));
            chk("score",     32'(score),     32'(vecs[i].sc));
            chk("count",     32'(count),     32'(vecs[i].cn));
            chk("natural",   32'(natural),   32'(vecs[i].nat));
            chk("full",      32'(full),      32'(vecs[i].ful));
            chk("err",       32'(err),       32'(vecs[i].er));
        end

        // Reset held several cycles with a live offer: never ready, nothing taken;
        // ready returns in the first cycle after release and upd_valid is one pulse.
        vidx = 100;
        @(negedge slow_clock);
        reset      = 1'b1;
        clear      = 1'b0;
        card_valid = 1'b1;
        card_hand  = 1'b1;
        card       = 4'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("ready_in_reset", 32'(card_ready), 32'd0);
            @(posedge slow_clock);
            #1;
            chk("upd_in_reset", 32'(upd_valid), 32'd0);
            chk("score_in_reset", 32'(score), 32'h00);
            @(negedge slow_clock);
        end
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(card_ready), 32'd1);
        @(posedge slow_clock);
        #1;
        chk("first_upd_valid", 32'(upd_valid), 32'd1);
        chk("first_upd_hand", 32'(upd_hand), 32'd1);
        chk("first_score", 32'(score), 32'h50);
        @(negedge slow_clock);
        card_valid = 1'b0;
        @(posedge slow_clock);
        #1;
        chk("upd_pulse_ends", 32'(upd_valid), 32'd0);
        chk("score_holds", 32'(score), 32'h50);
        chk("count_holds", 32'(count), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
